// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath: steps each instruction through fetch/decode/execute/memory/writeback
// over a shared variable-latency memory port; aborts stalled memory accesses and flags illegal opcodes (both sticky).
module mips_multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       bus_err,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDIEX   = 4'd10,
      S_ADDIWB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_illegal;
   logic             r_bus_err;

   state_t           w_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_wait_state;
   logic             w_timeout;
   logic             w_set_illegal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt_next;
         r_illegal <= r_illegal | w_set_illegal;
         r_bus_err <= r_bus_err | w_timeout;
      end
   end

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
   assign w_timeout    = w_wait_state && !mem_ready && (r_cnt == CNT_LAST);

   always_comb begin
      w_next        = S_FETCH;
      w_cnt_next    = '0;
      w_set_illegal = 1'b0;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXECUTE;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               OP_ADDI:      w_next = S_ADDIEX;
               default: begin
                  w_next        = S_FETCH;
                  w_set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  w_next = S_ALUWB;
         S_ADDIEX:   w_next = S_ADDIWB;
         default:    w_next = S_FETCH;
      endcase
      // Abort wins over staying put; a FETCH abort simply re-fetches from the unchanged PC.
      if (w_timeout) begin
         w_next = S_FETCH;
      end else if (w_wait_state && !mem_ready) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            S_ADDIWB:   reg_write = 1'b1;
            default:    ;
         endcase
      end
   end

   assign illegal_op = r_illegal;
   assign bus_err    = r_bus_err;
   assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, hand-written multi-cycle corner cases,
// and random instruction streams checked against an instruction-level path model.
module tb_mips_multicycle_ctrl;
   localparam int TO = 16;

   // Control vector order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
   localparam logic [15:0] C_FETCH_R = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
   localparam logic [15:0] C_FETCH_W = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
   localparam logic [15:0] C_DEC     = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
   localparam logic [15:0] C_MEMADR  = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [15:0] C_MEMRD   = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
   localparam logic [15:0] C_MEMWB   = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
   localparam logic [15:0] C_MEMWR   = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
   localparam logic [15:0] C_EXE     = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
   localparam logic [15:0] C_ALUWB   = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
   localparam logic [15:0] C_BRANCH  = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
   localparam logic [15:0] C_JUMP    = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
   localparam logic [15:0] C_ADDIWB  = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

   logic clk = 1'b0;
   logic reset;
   logic [5:0] opcode;
   logic mem_ready;
   logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic illegal_op, bus_err;
   logic [3:0] state;
   logic [15:0] w_ctl;

   int errors = 0;
   int checks = 0;
   bit exp_ill = 1'b0;
   bit exp_berr = 1'b0;

   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      int          st;
      logic [15:0] ctl;
   } vec_t;
   vec_t tbl[$];

   mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
   );

   assign w_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic check_now(input string tag, input int st, input logic [15:0] c);
      check({tag, " state"}, {28'd0, state}, st);
      check({tag, " ctl"}, {16'd0, w_ctl}, {16'd0, c});
      check({tag, " flags"}, {30'd0, illegal_op, bus_err}, {30'd0, exp_ill, exp_berr});
   endtask

   // One clock cycle: drive inputs just after the edge, compare mid-cycle, advance.
   task automatic cyc(input logic [5:0] op, input logic rdy, input int st,
                      input logic [15:0] c, input string tag);
      opcode = op;
      mem_ready = rdy;
      #2;
      check_now(tag, st, c);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b1;
      exp_ill = 1'b0;
      exp_berr = 1'b0;
      #2;
      check_now("in_reset", 0, 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic add(input logic [5:0] op, input logic rdy, input int st, input logic [15:0] c);
      vec_t v;
      v.op = op; v.rdy = rdy; v.st = st; v.ctl = c;
      tbl.push_back(v);
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
   endfunction

   function automatic logic [15:0] exp_ctl(input int s, input bit rdy);
      case (s)
         0:       return rdy ? C_FETCH_R : C_FETCH_W;
         1:       return C_DEC;
         2, 10:   return C_MEMADR;
         3:       return C_MEMRD;
         4:       return C_MEMWB;
         5:       return C_MEMWR;
         6:       return C_EXE;
         7:       return C_ALUWB;
         8:       return C_BRANCH;
         9:       return C_JUMP;
         11:      return C_ADDIWB;
         default: return 16'd0;
      endcase
   endfunction

   // Instruction-level model: the list of steps an opcode walks, with the
   // memory steps consuming random ready cycles and aborting after TO misses.
   task automatic run_instr(input logic [5:0] op, input int stall_pct);
      int path[$];
      int i;
      int s;
      int waits;
      bit rdy;
      path = '{0, 1};
      case (op)
         OP_R:    path = '{0, 1, 6, 7};
         OP_ADDI: path = '{0, 1, 10, 11};
         OP_LW:   path = '{0, 1, 2, 3, 4};
         OP_SW:   path = '{0, 1, 2, 5};
         OP_BEQ:  path = '{0, 1, 8};
         OP_J:    path = '{0, 1, 9};
         default: path = '{0, 1};
      endcase
      i = 0;
      waits = 0;
      while (i < path.size()) begin
         s = path[i];
         if (s == 0 || s == 3 || s == 5) begin
            rdy = ($urandom_range(99) >= stall_pct);
            cyc((s == 0) ? 6'($urandom) : op, rdy, s, exp_ctl(s, rdy), "rand_mem");
            if (rdy) begin
               waits = 0;
               i++;
            end else begin
               waits++;
               if (waits == TO) begin
                  waits = 0;
                  exp_berr = 1'b1;
                  i = (s == 0) ? 0 : path.size();
               end
            end
         end else begin
            rdy = 1'($urandom);
            cyc(op, rdy, s, exp_ctl(s, rdy), "rand_step");
            if (s == 1 && !is_legal(op)) exp_ill = 1'b1;
            i++;
         end
      end
   endtask

   initial begin
      logic [5:0] op;
      int sel;

      add(OP_R, 1, 0, C_FETCH_R);  add(OP_R, 1, 1, C_DEC);
      add(OP_R, 1, 6, C_EXE);      add(OP_R, 1, 7, C_ALUWB);
      add(OP_SW, 1, 0, C_FETCH_R); add(OP_SW, 1, 1, C_DEC);
      add(OP_SW, 1, 2, C_MEMADR);  add(OP_SW, 1, 5, C_MEMWR);
      add(OP_BEQ, 1, 0, C_FETCH_R); add(OP_BEQ, 1, 1, C_DEC);
      add(OP_BEQ, 1, 8, C_BRANCH);
      add(OP_J, 1, 0, C_FETCH_R);  add(OP_J, 1, 1, C_DEC);
      add(OP_J, 0, 9, C_JUMP);
      add(OP_ADDI, 1, 0, C_FETCH_R); add(OP_ADDI, 0, 1, C_DEC);
      add(OP_ADDI, 0, 10, C_MEMADR); add(OP_ADDI, 1, 11, C_ADDIWB);
      add(OP_R, 0, 0, C_FETCH_W);

      opcode = OP_R;
      mem_ready = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      foreach (tbl[k]) cyc(tbl[k].op, tbl[k].rdy, tbl[k].st, tbl[k].ctl, $sformatf("vec%0d", k));

      // lw with three not-ready cycles in MEMREAD: eight cycles total.
      do_reset();
      cyc(OP_LW, 1, 0, C_FETCH_R, "lw_fetch");
      cyc(OP_LW, 1, 1, C_DEC, "lw_dec");
      cyc(OP_LW, 1, 2, C_MEMADR, "lw_adr");
      for (int w = 0; w < 3; w++) cyc(OP_LW, 0, 3, C_MEMRD, "lw_wait");
      cyc(OP_LW, 1, 3, C_MEMRD, "lw_rd");
      cyc(OP_LW, 0, 4, C_MEMWB, "lw_wb");
      cyc(OP_R, 0, 0, C_FETCH_W, "lw_done");

      // Illegal opcode: sticky through later valid instructions.
      do_reset();
      cyc(6'h3F, 1, 0, C_FETCH_R, "ill_fetch");
      cyc(6'h3F, 1, 1, C_DEC, "ill_dec");
      exp_ill = 1'b1;
      cyc(OP_J, 1, 0, C_FETCH_R, "ill_after");
      cyc(OP_J, 1, 1, C_DEC, "ill_j_dec");
      cyc(OP_J, 1, 9, C_JUMP, "ill_j");
      cyc(OP_R, 0, 0, C_FETCH_W, "ill_sticky");

      // FETCH timeout: sixteen not-ready cycles, then bus_err, state stays FETCH.
      do_reset();
      for (int w = 0; w < TO; w++) cyc(OP_R, 0, 0, C_FETCH_W, "to_wait");
      exp_berr = 1'b1;
      cyc(OP_R, 0, 0, C_FETCH_W, "to_abort");
      cyc(OP_R, 1, 0, C_FETCH_R, "to_refetch");
      cyc(OP_R, 1, 1, C_DEC, "to_dec");

      // Reset mid-instruction: immediate FETCH, no writeback strobes.
      cyc(OP_R, 1, 6, C_EXE, "mid_exe");
      reset = 1'b1;
      exp_berr = 1'b0;
      #1;
      check_now("mid_reset", 0, 16'd0);
      @(posedge clk);
      #1;
      check_now("mid_reset_hold", 0, 16'd0);
      reset = 1'b0;
      cyc(OP_R, 1, 0, C_FETCH_R, "mid_release");
      cyc(OP_R, 1, 1, C_DEC, "mid_dec");
      cyc(OP_R, 1, 6, C_EXE, "mid_exe2");
      cyc(OP_R, 1, 7, C_ALUWB, "mid_wb");

      // Random instruction stream against the path model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 6);
         case (sel)
            0: op = OP_R;
            1: op = OP_ADDI;
            2: op = OP_LW;
            3: op = OP_SW;
            4: op = OP_BEQ;
            5: op = OP_J;
            default: begin
               op = 6'($urandom);
               while (is_legal(op)) op = 6'($urandom);
            end
         endcase
         run_instr(op, ($urandom_range(0, 9) == 0) ? 96 : 25);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the 32-bit MIPS datapath. It replaces single-cycle control when instruction and data memory share one port with variable latency. It is a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath mux and write-enable. It waits on a memory ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 16, max consecutive not-ready cycles tolerated in a memory state before abort
CNT_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES-1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  instr[31:26] from the instruction register; stable from DECODE until return to FETCH
mem_ready  input  1  shared memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified by ALU zero (beq)
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  writeback select: 1=MDR, 0=ALUOut
reg_dst  output  1  write register select: 1=rd, 0=rt
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select: 0=PC, 1=rs data
alu_src_b  output  2  ALU B select: 00=rt data, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  to ALU control: 00 add, 01 sub, 10 funct
pc_source  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump address
illegal_op  output  1  sticky: unsupported opcode decoded
bus_err  output  1  sticky: memory timeout occurred
state  output  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset: state=FETCH(0), wait counter=0, illegal_op=0, bus_err=0. While reset is high, all control outputs are forced to 0.
- Outputs: combinational decode of the registered state, plus mem_ready gating where noted. Any output not listed for a state is 0.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write = mem_ready. mem_ready=1 -> DECODE; else stay.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - other -> FETCH and set illegal_op
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD(3): mem_read=1, i_or_d=1. mem_ready -> MEMWB; else stay.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWRITE(5): mem_write=1, i_or_d=1. mem_ready -> FETCH; else stay (mem_write held high).
- EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP(9): pc_write=1, pc_source=10 -> FETCH.
- ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Encodings 12-15: all outputs 0; next state FETCH.
- Wait counter (FETCH, MEMREAD, MEMWRITE only):
  - increments each cycle with mem_ready=0; clears on any state change or mem_ready=1.
  - mem_ready=0 with counter==TIMEOUT_CYCLES-1: set bus_err, next state FETCH, counter cleared. In that cycle ir_write, pc_write and reg_write stay 0.
  - Abort from FETCH re-fetches the same PC.
- Zero-wait latencies, in cycles: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each wait cycle adds 1.
- Sticky flags clear only on reset; they do not stall sequencing.
- Reset asserted mid-instruction returns to FETCH immediately; no partial writeback.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 -> state 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. pc_write=ir_write=1 only in state 0.
- lw (100011), mem_ready low for 3 cycles in MEMREAD -> state 3 held 4 cycles with mem_read=i_or_d=1, then MEMWB with reg_write=1, mem_to_reg=1. Total 8 cycles.
- sw (101011), mem_ready=1 -> states 0,1,2,5,0. mem_write=1 only in state 5. reg_write never 1.
- beq then j -> BRANCH drives pc_write_cond=1, pc_source=01, alu_op=01. JUMP drives pc_write=1, pc_source=10. Each takes 3 cycles.
- opcode=111111 -> DECODE then FETCH; illegal_op rises and stays 1 through later valid instructions until reset.
- mem_ready held 0 in FETCH with TIMEOUT_CYCLES=16 -> after 16 cycles bus_err=1, state stays 0, ir_write never asserted. Reset clears bus_err.
